// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types for the intersection phase scheduler: light codes and FSM states.
package intersection_phase_scheduler_pkg;

    typedef logic [1:0] light_t;

    localparam light_t LIGHT_RED    = 2'd0;
    localparam light_t LIGHT_YELLOW = 2'd1;
    localparam light_t LIGHT_GREEN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_ALL_RED = 2'd3
    } sched_state_t;

endpackage

// File: rtl/intersection_phase_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of pending strictly after ptr, wrapping.
module intersection_phase_scheduler_rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);

    logic [W-1:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = W'((32'(ptr) + k) % N);
            if (!valid && pending[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin phase scheduler: GREEN -> YELLOW -> ALL_RED per grant, with emergency preempt.
module intersection_phase_scheduler
    import intersection_phase_scheduler_pkg::*;
#(
    parameter int unsigned N_APPR       = 4,
    parameter int unsigned GREEN_MIN    = 6,
    parameter int unsigned GREEN_MAX    = 20,
    parameter int unsigned YELLOW_TIME  = 4,
    parameter int unsigned ALL_RED_TIME = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_APPR-1:0]         req,
    input  logic                      preempt,
    input  logic [$clog2(N_APPR)-1:0] preempt_idx,
    output logic [2*N_APPR-1:0]       lights,
    output logic [$clog2(N_APPR)-1:0] grant_idx,
    output logic                      phase_start,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(N_APPR);
    localparam int unsigned TW = $clog2(GREEN_MAX + 1);

    sched_state_t      state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [N_APPR-1:0] pending_q, pending_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     grant_q, grant_d;

    logic [N_APPR-1:0] eff_pend;
    logic [N_APPR-1:0] others;
    logic [IW-1:0]     rr_idx;
    logic              rr_valid;
    logic [IW-1:0]     win_idx;
    logic              win_valid;
    logic              enter;
    light_t            code;

    assign eff_pend  = pending_q | req;
    assign others    = eff_pend & ~(N_APPR'(1) << grant_q);
    assign win_idx   = preempt ? preempt_idx : rr_idx;
    assign win_valid = preempt | rr_valid;

    intersection_phase_scheduler_rr_pick #(
        .N (N_APPR),
        .W (IW)
    ) u_rr_pick (
        .pending (eff_pend),
        .ptr     (rr_ptr_q),
        .idx     (rr_idx),
        .valid   (rr_valid)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        enter    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_valid) enter = 1'b1;
            end
            S_GREEN: begin
                // A preempt for the current owner pins the phase, suspending GREEN_MAX
                if (preempt) begin
                    if (preempt_idx != grant_q) state_d = S_YELLOW;
                end else if (timer_q == TW'(GREEN_MAX - 1)) begin
                    state_d = S_YELLOW;
                end else if (timer_q >= TW'(GREEN_MIN - 1) && ((|others) || !req[grant_q])) begin
                    state_d = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (timer_q == TW'(YELLOW_TIME - 1)) state_d = S_ALL_RED;
            end
            S_ALL_RED: begin
                if (timer_q == TW'(ALL_RED_TIME - 1)) begin
                    if (win_valid) enter = 1'b1;
                    else           state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter) begin
            state_d = S_GREEN;
            grant_d = win_idx;
            if (!preempt) rr_ptr_d = rr_idx;
        end

        pending_d = eff_pend;
        if (enter) pending_d[win_idx] = 1'b0;

        if (state_d != state_q)  timer_d = '0;
        else if (timer_q == '1)  timer_d = timer_q;
        else                     timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            rr_ptr_q  <= IW'(N_APPR - 1);
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
        end
    end

    always_comb begin
        case (state_q)
            S_GREEN:  code = LIGHT_GREEN;
            S_YELLOW: code = LIGHT_YELLOW;
            default:  code = LIGHT_RED;
        endcase
    end

    assign lights      = {{(2*N_APPR-2){1'b0}}, code} << {grant_q, 1'b0};
    assign grant_idx   = grant_q;
    assign phase_start = (state_q == S_GREEN) && (timer_q == '0);
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed self-checking bench for intersection_phase_scheduler (4 approaches, default timing).
module tb_intersection_phase_scheduler;

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       preempt;
    logic [1:0] preempt_idx;
    logic [7:0] lights;
    logic [1:0] grant_idx;
    logic       phase_start;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    intersection_phase_scheduler #(
        .N_APPR       (4),
        .GREEN_MIN    (6),
        .GREEN_MAX    (20),
        .YELLOW_TIME  (4),
        .ALL_RED_TIME (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .preempt     (preempt),
        .preempt_idx (preempt_idx),
        .lights      (lights),
        .grant_idx   (grant_idx),
        .phase_start (phase_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic [1:0] code, input int idx);
        logic [7:0] v;
        v = {6'b0, code};
        return v << (2 * idx);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Check one phase segment cycle by cycle; fresh marks the first cycle of a new grant.
    task automatic run(input string tag, input logic [1:0] code, input int idx, input int n,
                       input bit fresh);
        for (int k = 0; k < n; k++) begin
            chk({tag, "/lights"}, 32'(lights), 32'(mk(code, idx)));
            chk({tag, "/grant"}, 32'(grant_idx), 32'(idx));
            chk({tag, "/busy"}, 32'(busy), 32'd1);
            chk({tag, "/phase_start"}, 32'(phase_start),
                (code == GRN && k == 0 && fresh) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "/lights"}, 32'(lights), 32'h0);
        chk({tag, "/busy"}, 32'(busy), 32'd0);
        chk({tag, "/phase_start"}, 32'(phase_start), 32'd0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req         = '0;
        preempt     = 1'b0;
        preempt_idx = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset/grant", 32'(grant_idx), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single pulse on approach 2, minimum green then back to idle
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        run("t1_green", GRN, 2, 6, 1'b1);
        run("t1_yellow", YEL, 2, 4, 1'b0);
        run("t1_allred", RED, 2, 2, 1'b0);
        check_idle("t1_idle");
        chk("t1_idle/grant_hold", 32'(grant_idx), 32'd2);

        // 2: held request with no competitor runs to GREEN_MAX, then re-granted
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        run("t2_green", GRN, 1, 20, 1'b1);
        run("t2_yellow", YEL, 1, 4, 1'b0);
        run("t2_allred", RED, 1, 2, 1'b0);
        run("t2_regrant", GRN, 1, 1, 1'b1);

        // 3: competitor arrives mid-green, owner cut at GREEN_MIN
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        run("t3_green_a", GRN, 0, 2, 1'b1);
        req = 4'b1001;
        run("t3_green_b", GRN, 0, 4, 1'b0);
        req = '0;
        run("t3_yellow", YEL, 0, 4, 1'b0);
        run("t3_allred", RED, 0, 2, 1'b0);
        run("t3_next", GRN, 3, 1, 1'b1);

        // 4: all approaches at once, served 0,1,2,3 in order
        do_reset();
        req = 4'b1111;
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            run($sformatf("t4_green%0d", i), GRN, i, 6, 1'b1);
            run($sformatf("t4_yellow%0d", i), YEL, i, 4, 1'b0);
            run($sformatf("t4_allred%0d", i), RED, i, 2, 1'b0);
        end
        check_idle("t4_idle");

        // 5: preempt to approach 0 during approach 2 green; rr pointer stays at 2
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        req         = '0;
        preempt     = 1'b1;
        preempt_idx = 2'd0;
        run("t5_green2", GRN, 2, 1, 1'b1);
        run("t5_yellow2", YEL, 2, 4, 1'b0);
        run("t5_allred2", RED, 2, 2, 1'b0);
        run("t5_pre_green0", GRN, 0, 25, 1'b1);
        preempt = 1'b0;
        req     = 4'b1010;
        run("t5_release", GRN, 0, 1, 1'b0);
        req = '0;
        run("t5_yellow0", YEL, 0, 4, 1'b0);
        run("t5_allred0", RED, 0, 2, 1'b0);
        run("t5_rr_next", GRN, 3, 1, 1'b1);

        // 6: asynchronous reset mid-yellow clears lights and pending
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        run("t6_green_a", GRN, 0, 2, 1'b1);
        req = 4'b0100;
        run("t6_green_b", GRN, 0, 1, 1'b0);
        req = '0;
        run("t6_green_c", GRN, 0, 3, 1'b0);
        run("t6_yellow", YEL, 0, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle("t6_async");
        chk("t6_async/grant", 32'(grant_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_idle("t6_after");
            @(negedge clk);
        end
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        run("t6_regrant", GRN, 0, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
